ifm_sparse_loader: RTL and testbench

Streaming writer for the IFM chunk memory. It accepts dense 8-bit IFM bytes one bus beat at a time over a valid/ready handshake and encodes each beat into a sparsemap plus left-compacted nonzero data. It also sequences the memory's write-side data-count and chunk-count indices. It sits between the DMA/bus front end and the IFM memory write port, and is the producer side of that port.

---
 rtl/ifm_sparse_loader_pkg.sv | 42 ++++
 rtl/ifm_sparse_loader_pack.sv | 26 ++
 rtl/ifm_sparse_loader.sv | 114 +++++++++++
 tb/tb_ifm_sparse_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ifm_sparse_loader_pkg.sv
// Shared IFM memory geometry and loader FSM states, imported by the IFM memory and its loader.
// Geometry follows the Global_Include.vh macros; the fallbacks below are used when they are absent.
`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 8
`endif
`ifndef CHANNEL_NUM
`define CHANNEL_NUM 4
`endif
`ifndef OUTPUT_BUF_NUM
`define OUTPUT_BUF_NUM 2
`endif

package npu_ifm_pkg;
    localparam int BUS_SIZE             = `BUS_SIZE;
    localparam int CHUNK_SIZE           = `MEM_SIZE;
    localparam int FILTER_NUM           = CHUNK_SIZE / `CHANNEL_NUM;
    localparam int OUTPUT_NUM           = (FILTER_NUM < `OUTPUT_BUF_NUM) ? FILTER_NUM : `OUTPUT_BUF_NUM;
    localparam int IFM_NUM              = FILTER_NUM + OUTPUT_NUM;
    localparam int PARAM_WR_DAT_CYC_NUM = `MEM_SIZE / `BUS_SIZE;

    // Index widths are kept at least one bit so degenerate geometries still elaborate.
    localparam int CHUNK_W = (IFM_NUM > 1) ? $clog2(IFM_NUM) : 1;
    localparam int DAT_W   = (PARAM_WR_DAT_CYC_NUM > 1) ? $clog2(PARAM_WR_DAT_CYC_NUM) : 1;
    localparam int POS_W   = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;
    localparam int ZCNT_W  = $clog2(IFM_NUM * CHUNK_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ifm_ld_state_e;

    function automatic logic [ZCNT_W-1:0] zero_lanes(input logic [BUS_SIZE-1:0] map);
        zero_lanes = ZCNT_W'(BUS_SIZE);
        for (int i = 0; i < BUS_SIZE; i++) begin
            if (map[i]) zero_lanes = zero_lanes - ZCNT_W'(1);
        end
    endfunction
endpackage

// File: rtl/ifm_sparse_loader_pack.sv
// Combinational sparse encoder: one dense beat in, sparsemap plus left-compacted nonzero bytes out.
// Each nonzero lane lands at the slot given by the count of nonzero lanes below it.
module ifm_sparse_pack
    import npu_ifm_pkg::*;
(
    input  logic [BUS_SIZE*8-1:0] data_i,
    output logic [BUS_SIZE-1:0]   sparsemap_o,
    output logic [BUS_SIZE*8-1:0] nonzero_data_o
);
    logic [POS_W-1:0] pos [BUS_SIZE];

    always_comb begin
        sparsemap_o    = '0;
        nonzero_data_o = '0;
        for (int k = 0; k < BUS_SIZE; k++) begin
            sparsemap_o[k] = |data_i[k*8 +: 8];
        end
        pos[0] = '0;
        for (int k = 1; k < BUS_SIZE; k++) begin
            pos[k] = pos[k-1] + POS_W'(sparsemap_o[k-1]);
        end
        for (int k = 0; k < BUS_SIZE; k++) begin
            if (sparsemap_o[k]) nonzero_data_o[{pos[k], 3'b000} +: 8] = data_i[k*8 +: 8];
        end
    end
endmodule

// File: rtl/ifm_sparse_loader.sv
// IFM chunk-memory writer: sparse-encodes accepted beats and sequences the write-side beat/chunk indices.
// Optional zero-byte counter port zero_cnt_o is enabled by IFM_SPARSE_LOADER_ZERO_CNT_EN.
module ifm_sparse_loader
    import npu_ifm_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CHUNK_W-1:0]    chunk_last_i,
    input  logic [BUS_SIZE*8-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
    output logic                  wr_valid_o,
    output logic [DAT_W-1:0]      wr_dat_count_o,
    output logic [CHUNK_W-1:0]    wr_chunk_count_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef IFM_SPARSE_LOADER_ZERO_CNT_EN
    ,
    output logic [ZCNT_W-1:0]     zero_cnt_o
`endif
);
    localparam logic [DAT_W-1:0]   DAT_LAST   = DAT_W'(PARAM_WR_DAT_CYC_NUM - 1);
    localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(IFM_NUM - 1);

    ifm_ld_state_e          state_q, state_d;
    logic [CHUNK_W-1:0]     last_chunk_q;
    logic [DAT_W-1:0]       dat_cnt_q;
    logic [CHUNK_W-1:0]     chunk_cnt_q;
    logic [BUS_SIZE-1:0]    sparsemap_p0;
    logic [BUS_SIZE*8-1:0]  nzdata_p0;
    logic                   vld_p0;
    logic                   start_ok;
    logic                   last_beat;

    ifm_sparse_pack u_pack (
        .data_i         (in_data_i),
        .sparsemap_o    (sparsemap_p0),
        .nonzero_data_o (nzdata_p0)
    );

    assign vld_p0    = in_valid_i && (state_q == LOAD);
    assign start_ok  = start_i && (state_q == IDLE);
    assign last_beat = (dat_cnt_q == DAT_LAST) && (chunk_cnt_q == last_chunk_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                in_ready_o = 1'b1;
                if (vld_p0 && last_beat) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // p0 -> p1: register the encoded beat with the indices it was accepted under
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_chunk_q      <= '0;
            dat_cnt_q         <= '0;
            chunk_cnt_q       <= '0;
            wr_valid_o        <= 1'b0;
            wr_sparsemap_o    <= '0;
            wr_nonzero_data_o <= '0;
            wr_dat_count_o    <= '0;
            wr_chunk_count_o  <= '0;
        end else begin
            wr_valid_o <= vld_p0;
            if (start_ok) begin
                last_chunk_q <= (chunk_last_i > CHUNK_LAST) ? CHUNK_LAST : chunk_last_i;
                dat_cnt_q    <= '0;
                chunk_cnt_q  <= '0;
            end
            if (vld_p0) begin
                wr_sparsemap_o    <= sparsemap_p0;
                wr_nonzero_data_o <= nzdata_p0;
                wr_dat_count_o    <= dat_cnt_q;
                wr_chunk_count_o  <= chunk_cnt_q;
                if (dat_cnt_q == DAT_LAST) begin
                    dat_cnt_q   <= '0;
                    chunk_cnt_q <= chunk_cnt_q + CHUNK_W'(1);
                end else begin
                    dat_cnt_q <= dat_cnt_q + DAT_W'(1);
                end
            end
        end
    end

`ifdef IFM_SPARSE_LOADER_ZERO_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) zero_cnt_o <= '0;
        else if (vld_p0)       zero_cnt_o <= zero_cnt_o + zero_lanes(sparsemap_p0);
    end
`endif
endmodule

// File: tb/tb_ifm_sparse_loader.sv
// Directed-plus-random bench for ifm_sparse_loader (4-lane bus, 2 beats/chunk, 4 chunks).
// Expected encodings and indices come from a beat-counting queue model.
module tb_ifm_sparse_loader;
    import npu_ifm_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  start_i = 1'b0;
    logic [CHUNK_W-1:0]    chunk_last_i = '0;
    logic [BUS_SIZE*8-1:0] in_data_i = '0;
    logic                  in_valid_i = 1'b0;
    logic                  in_ready_o;
    logic [BUS_SIZE-1:0]   wr_sparsemap_o;
    logic [BUS_SIZE*8-1:0] wr_nonzero_data_o;
    logic                  wr_valid_o;
    logic [DAT_W-1:0]      wr_dat_count_o;
    logic [CHUNK_W-1:0]    wr_chunk_count_o;
    logic                  busy_o;
    logic                  done_o;
`ifdef IFM_SPARSE_LOADER_ZERO_CNT_EN
    logic [ZCNT_W-1:0]     zero_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state: beats accepted in the current load, its final chunk, zero bytes seen.
    bit loading = 0;
    int idx = 0;
    int last = 0;
    int zeros = 0;

    ifm_sparse_loader dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .chunk_last_i      (chunk_last_i),
        .in_data_i         (in_data_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .wr_sparsemap_o    (wr_sparsemap_o),
        .wr_nonzero_data_o (wr_nonzero_data_o),
        .wr_valid_o        (wr_valid_o),
        .wr_dat_count_o    (wr_dat_count_o),
        .wr_chunk_count_o  (wr_chunk_count_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
`ifdef IFM_SPARSE_LOADER_ZERO_CNT_EN
        ,
        .zero_cnt_o        (zero_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void encode(input logic [31:0] d, output logic [3:0] m, output logic [31:0] o);
        logic [7:0] q[$];
        m = '0;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            if (d[i*8 +: 8] != 8'h00) begin
                m[i] = 1'b1;
                q.push_back(d[i*8 +: 8]);
            end
        end
        foreach (q[j]) o[j*8 +: 8] = q[j];
    endfunction

    function automatic logic [31:0] rnd_beat();
        logic [31:0] d = '0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) != 0) d[i*8 +: 8] = 8'($urandom_range(1, 255));
        end
        return d;
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready_o), 0);
        chk({tag, "_wvalid"}, 32'(wr_valid_o), 0);
        chk({tag, "_map"}, 32'(wr_sparsemap_o), 0);
        chk({tag, "_data"}, wr_nonzero_data_o, 0);
        chk({tag, "_dat"}, 32'(wr_dat_count_o), 0);
        chk({tag, "_chunk"}, 32'(wr_chunk_count_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
`ifdef IFM_SPARSE_LOADER_ZERO_CNT_EN
        chk({tag, "_zcnt"}, 32'(zero_cnt_o), 0);
`endif
    endtask

    task automatic start(input int c);
        start_i = 1'b1;
        chunk_last_i = CHUNK_W'(c);
        step();
        start_i = 1'b0;
        loading = 1;
        idx = 0;
        last = (c > IFM_NUM - 1) ? IFM_NUM - 1 : c;
        zeros = 0;
        chk("start_ready", 32'(in_ready_o), 1);
        chk("start_busy", 32'(busy_o), 1);
    endtask

    task automatic beat(input bit v, input logic [31:0] d);
        logic [3:0] m;
        logic [31:0] o;
        bit fin;
        in_valid_i = v;
        in_data_i = d;
        step();
        if (v && loading) begin
            encode(d, m, o);
            fin = (idx == (last + 1) * PARAM_WR_DAT_CYC_NUM - 1);
            chk("wr_valid", 32'(wr_valid_o), 1);
            chk("wr_map", 32'(wr_sparsemap_o), 32'(m));
            chk("wr_data", wr_nonzero_data_o, o);
            chk("wr_chunk", 32'(wr_chunk_count_o), idx / PARAM_WR_DAT_CYC_NUM);
            chk("wr_dat", 32'(wr_dat_count_o), idx % PARAM_WR_DAT_CYC_NUM);
            chk("done", 32'(done_o), 32'(fin));
            for (int i = 0; i < 4; i++) if (!m[i]) zeros++;
            idx++;
            if (fin) begin
                loading = 0;
                chk("done_ready", 32'(in_ready_o), 0);
                chk("done_busy", 32'(busy_o), 1);
            end
        end else begin
            chk("idle_wvalid", 32'(wr_valid_o), 0);
        end
    endtask

    task automatic back_to_idle();
        in_valid_i = 1'b0;
        step();
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_done", 32'(done_o), 0);
        chk("idle_wvalid", 32'(wr_valid_o), 0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        all_zero("reset");
        rst_i = 1'b0;
        step();
        all_zero("post_reset");

        // Full load of 4 chunks; first beat is the directed encode case
        start(3);
        beat(1'b1, 32'h0700_0500);
        chk("enc_map", 32'(wr_sparsemap_o), 32'h0000_000a);
        chk("enc_data", wr_nonzero_data_o, 32'h0000_0705);
        for (int i = 1; i < 8; i++) beat(1'b1, rnd_beat());
        back_to_idle();

        // Gaps, partial load, start during LOAD ignored, all-zero and all-nonzero beats
        start(0);
        beat(1'b1, 32'h0000_0000);
        chk("zero_map", 32'(wr_sparsemap_o), 0);
        beat(1'b0, rnd_beat());
        start_i = 1'b1;
        chunk_last_i = CHUNK_W'(3);
        beat(1'b0, rnd_beat());
        start_i = 1'b0;
        beat(1'b1, 32'h0403_0201);
        chk("full_map", 32'(wr_sparsemap_o), 32'h0000_000f);
        chk("full_data", wr_nonzero_data_o, 32'h0403_0201);
        chk("gap_done", 32'(done_o), 1);
        back_to_idle();

        // Reset mid-load after 3 beats
        start(3);
        for (int i = 0; i < 3; i++) beat(1'b1, rnd_beat());
        in_valid_i = 1'b1;
        in_data_i = 32'h0102_0304;
        rst_i = 1'b1;
        step();
        all_zero("midrst");
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        loading = 0;

        // Fresh start with random valid gaps until the load completes
        start(3);
        beat(1'b1, rnd_beat());
        for (int n = 0; n < 200 && loading; n++) beat($urandom_range(0, 3) != 0, rnd_beat());
        chk("load_complete", 32'(loading), 0);
        back_to_idle();

`ifdef IFM_SPARSE_LOADER_ZERO_CNT_EN
        start(0);
        beat(1'b1, 32'h0700_0500);
        beat(1'b1, 32'h0000_0000);
        chk("zcnt", 32'(zero_cnt_o), 32'(zeros));
        chk("zcnt_six", 32'(zero_cnt_o), 6);
        back_to_idle();
        chk("zcnt_hold", 32'(zero_cnt_o), 6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
